// File: rtl/alu_seq.sv
// Purpose: execute-stage ALU with MIPS R-type funct set and iterative mult/div into HI/LO.
// Latency: single-cycle ops -> out_valid 1 cycle after accept; mult/div -> WIDTH+1 cycles after accept.
// Backpressure: no output backpressure; in_ready low while a mult/div is in flight (MUL/DIV/DONE).
// Ports: clk/rst (sync, active-high), clk_en freezes all state; in_valid/in_ready issue handshake;
//        func/shamt/operand_a/operand_b op inputs; out_valid/result/flags{neg,zero,ovf,eq}/illegal
//        registered outputs; hi/lo architectural multiply/divide registers.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic             accept, is_mul, is_div, sgn, last;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mag_a, mag_b;
    // acc_hi/acc_lo: partial product (mult) or remainder/quotient-shift (div)
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_save;
    logic             neg_lo, neg_hi, dz, ovf_save, eq_save;

    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_ovf, sc_ill;
    logic [WIDTH:0]   madd, trial;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
    logic [WIDTH-1:0] quo, rem, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & clk_en;
    assign is_mul   = (func == 6'd24) || (func == 6'd25);
    assign is_div   = (func == 6'd26) || (func == 6'd27);
    assign sgn      = (func == 6'd24) || (func == 6'd26);
    assign mag_a    = (sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign mag_b    = (sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    assign last     = (cnt == SHW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)      state_nx = MUL;
                else if (is_div) state_nx = DIV;
            end
            MUL, DIV: if (clk_en && last) state_nx = DONE;
            DONE:     if (clk_en) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        sum    = operand_a + operand_b;
        diff   = operand_a - operand_b;
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (func)
            6'd32: begin
                sc_res = sum;
                sc_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            6'd33: sc_res = sum;
            6'd34: begin
                sc_res = diff;
                sc_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            6'd35: sc_res = diff;
            6'd36: sc_res = operand_a & operand_b;
            6'd37: sc_res = operand_a | operand_b;
            6'd38: sc_res = operand_a ^ operand_b;
            6'd39: sc_res = ~(operand_a | operand_b);
            6'd42: sc_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            6'd43: sc_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            6'd0:  sc_res = operand_a << shamt;
            6'd2:  sc_res = operand_a >> shamt;
            6'd3:  sc_res = $unsigned($signed(operand_a) >>> shamt);
            6'd4:  sc_res = operand_a << operand_b[SHW-1:0];
            6'd6:  sc_res = operand_a >> operand_b[SHW-1:0];
            6'd7:  sc_res = $unsigned($signed(operand_a) >>> operand_b[SHW-1:0]);
            6'd16: sc_res = hi;
            6'd18: sc_res = lo;
            6'd24, 6'd25, 6'd26, 6'd27: sc_res = '0; // handled by the iterative unit
            default: sc_ill = 1'b1;
        endcase
    end

    // ---------------- iterative step logic ----------------
    always_comb begin
        // shift-add: add multiplicand when multiplier LSB set, then shift the pair right
        madd      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_nx = madd[WIDTH:1];
        mul_lo_nx = {madd[0], acc_lo[WIDTH-1:1]};
        // restoring divide: borrow (trial MSB) means the subtraction is discarded
        trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
        if (!trial[WIDTH]) begin
            div_hi_nx = trial[WIDTH-1:0];
            div_lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_nx = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            div_lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // sign fix-up and divide-by-zero override applied to the final step's values
    always_comb begin
        prod = {mul_hi_nx, mul_lo_nx};
        if (neg_lo) prod = -prod;
        quo = neg_lo ? -div_lo_nx : div_lo_nx;
        rem = neg_hi ? -div_hi_nx : div_hi_nx;
        if (dz) begin
            quo = '1;
            rem = a_save;
        end
        if (state == DIV) begin
            fin_hi = rem;
            fin_lo = quo;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            a_save    <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            dz        <= 1'b0;
            ovf_save  <= 1'b0;
            eq_save   <= 1'b0;
        end else if (clk_en) begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_mul || is_div) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= is_mul ? mag_b : mag_a;
                        opnd     <= is_mul ? mag_a : mag_b;
                        a_save   <= operand_a;
                        eq_save  <= (operand_a == operand_b);
                        neg_lo   <= sgn && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_hi   <= is_div && sgn && operand_a[WIDTH-1];
                        dz       <= is_div && (operand_b == '0);
                        ovf_save <= is_div && ((operand_b == '0) ||
                                    (sgn && (operand_a == MIN_VAL) && (operand_b == '1)));
                    end else begin
                        out_valid <= 1'b1;
                        result    <= sc_res;
                        illegal   <= sc_ill;
                        flags     <= sc_ill ? 4'b0000 :
                                     {sc_res[WIDTH-1], sc_res == '0, sc_ovf, operand_a == operand_b};
                    end
                end
                MUL, DIV: begin
                    acc_hi <= (state == DIV) ? div_hi_nx : mul_hi_nx;
                    acc_lo <= (state == DIV) ? div_lo_nx : mul_lo_nx;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        hi        <= fin_hi;
                        lo        <= fin_lo;
                        result    <= fin_lo;
                        illegal   <= 1'b0;
                        flags     <= {fin_lo[WIDTH-1], fin_lo == '0, ovf_save, eq_save};
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst, clk_en, in_valid, in_ready;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] operand_a, operand_b;
    logic        out_valid, illegal;
    logic [31:0] result, hi, lo;
    logic [3:0]  flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .shamt(shamt), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .result(result), .flags(flags), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        ill;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h", name, act, want);
    endtask

    // monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("result",  result,           mon_e.res);
                check("flags",   32'(flags),       32'(mon_e.fl));
                check("illegal", 32'(illegal),     32'(mon_e.ill));
                check("hi",      hi,               mon_e.ehi);
                check("lo",      lo,               mon_e.elo);
                check("latency", 32'(cyc),         32'(mon_e.cyc));
            end
        end
    end

    // called at a negedge; returns at the negedge after the accept edge
    task automatic drive(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e_in, input int lat, input bit push);
        exp_t e;
        int   tries;
        e = e_in;
        tries = 0;
        while (in_ready !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        check("in_ready before issue", 32'(in_ready), 32'd1);
        func = f; shamt = sa; operand_a = a; operand_b = b; in_valid = 1'b1;
        e.cyc = cyc + lat;
        if (push) sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_sc(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                            input logic ei);
        exp_t e;
        e = '{er, ef, ei, model_hi, model_lo, 0};
        drive(f, sa, a, b, e, 1, 1'b1);
    endtask

    task automatic issue_mc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic [3:0] ef,
                            input int extra, input bit push);
        exp_t e;
        if (push) begin
            model_hi = ehi;
            model_lo = elo;
        end
        e = '{elo, ef, 1'b0, ehi, elo, 0};
        drive(f, 5'd0, a, b, e, W + 1 + extra, push);
        check("busy after accept", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int waits;
        rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0;
        func = '0; shamt = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    result,         32'd0);
        check("reset flags",     32'(flags),     32'd0);
        check("reset illegal",   32'(illegal),   32'd0);
        check("reset hi",        hi,             32'd0);
        check("reset lo",        lo,             32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);

        // back-to-back single-cycle ops
        issue_sc(6'd32, 5'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1010, 1'b0);
        issue_sc(6'd33, 5'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1000, 1'b0);
        issue_sc(6'd34, 5'd0, 32'd5,         32'd5,         32'h0,         4'b0101, 1'b0);
        issue_sc(6'd39, 5'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 4'b1000, 1'b0);
        issue_sc(6'd3,  5'd4, 32'h8000_0000, 32'h0,         32'hF800_0000, 4'b1000, 1'b0);
        issue_sc(6'd42, 5'd0, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1'b0);
        issue_sc(6'd43, 5'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0100, 1'b0);
        issue_sc(6'd38, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'b1000, 1'b0);
        issue_sc(6'd4,  5'd9, 32'h1,         32'h24,        32'h10,        4'b0000, 1'b0);
        issue_sc(6'd2,  5'd31, 32'h8000_0000, 32'h0,        32'h1,         4'b0000, 1'b0);
        issue_sc(6'd34, 5'd0, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0010, 1'b0);
        issue_sc(6'd7,  5'd0, 32'hF000_0000, 32'h3C,        32'hFFFF_FFFF, 4'b1000, 1'b0);
        issue_sc(6'd1,  5'd0, 32'd3,         32'd3,         32'h0,         4'b0000, 1'b1);

        // multiply / divide
        issue_mc(6'd24, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4'b1000, 0, 1'b1);
        issue_sc(6'd16, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b1001, 1'b0);
        issue_sc(6'd18, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFEB, 4'b1001, 1'b0);
        issue_mc(6'd25, 32'hFFFF_FFFF, 32'd2, 32'h1,         32'hFFFF_FFFE, 4'b1000, 0, 1'b1);
        issue_mc(6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b1000, 0, 1'b1);
        issue_mc(6'd27, 32'd7,         32'd0, 32'd7,         32'hFFFF_FFFF, 4'b1010, 0, 1'b1);
        issue_mc(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 4'b1010, 0, 1'b1);

        // clock-enable stall mid-divide: result slips by exactly the frozen cycles
        issue_mc(6'd27, 32'd100, 32'd7, 32'd2, 32'd14, 4'b0000, 5, 1'b1);
        repeat (10) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;

        // reset mid-multiply: aborted, hi/lo cleared, no result
        issue_mc(6'd25, 32'd5, 32'd6, 32'h0, 32'h0, 4'b0000, 0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("abort hi",        hi,             32'd0);
        check("abort lo",        lo,             32'd0);
        check("abort in_ready",  32'(in_ready),  32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        repeat (45) @(negedge clk);
        issue_sc(6'd16, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0101, 1'b0);

        waits = 0;
        while (sbq.size() != 0 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
